// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one synchronous-read RAM port between two masters.
// One access is registered onto the RAM port per cycle; read results are tagged back to the issuer.
module mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [1:0]    i_m0_cmd,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_wdata,
    output logic          o_m0_gnt,
    output logic          o_m0_rvalid,
    input  logic [1:0]    i_m1_cmd,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_wdata,
    output logic          o_m1_gnt,
    output logic          o_m1_rvalid,
    output logic [DW-1:0] o_rdata,
    output logic [AW-1:0] o_ram_addr,
    output logic          o_ram_write,
    output logic [DW-1:0] o_ram_din,
    input  logic [DW-1:0] i_ram_dout
);
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [1:0] {G_NONE, G_M0, G_M1} grant_t;
    typedef enum logic [1:0] {T_NONE, T_M0, T_M1} tag_t;

    grant_t        r_g, w_g_nxt;
    tag_t          r_tag, w_tag_nxt;
    logic          r_prio, w_prio_nxt;
    logic [AW-1:0] r_ram_addr, w_addr_nxt;
    logic [DW-1:0] r_ram_din, w_din_nxt;
    logic          r_ram_write, w_write_nxt;
    logic          w_elig0, w_elig1;

    // A master granted last cycle is masked so a held request is not issued twice.
    assign w_elig0 = (i_m0_cmd == MREAD || i_m0_cmd == MWRITE) && r_g != G_M0;
    assign w_elig1 = (i_m1_cmd == MREAD || i_m1_cmd == MWRITE) && r_g != G_M1;

    always_comb begin
        w_g_nxt     = G_NONE;
        w_prio_nxt  = r_prio;
        w_addr_nxt  = r_ram_addr;
        w_din_nxt   = r_ram_din;
        w_write_nxt = 1'b0;
        w_tag_nxt   = r_ram_write ? T_NONE : r_g == G_M0 ? T_M0 : r_g == G_M1 ? T_M1 : T_NONE;
        if (w_elig0 && (!w_elig1 || !r_prio))
            w_g_nxt = G_M0;
        else if (w_elig1)
            w_g_nxt = G_M1;
        if (w_g_nxt == G_M0) begin
            w_prio_nxt  = 1'b1;
            w_addr_nxt  = i_m0_addr;
            w_din_nxt   = i_m0_wdata;
            w_write_nxt = i_m0_cmd == MWRITE;
        end else if (w_g_nxt == G_M1) begin
            w_prio_nxt  = 1'b0;
            w_addr_nxt  = i_m1_addr;
            w_din_nxt   = i_m1_wdata;
            w_write_nxt = i_m1_cmd == MWRITE;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_g         <= G_NONE;
            r_tag       <= T_NONE;
            r_prio      <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_ram_write <= 1'b0;
        end else begin
            r_g         <= w_g_nxt;
            r_tag       <= w_tag_nxt;
            r_prio      <= w_prio_nxt;
            r_ram_addr  <= w_addr_nxt;
            r_ram_din   <= w_din_nxt;
            r_ram_write <= w_write_nxt;
        end
    end

    assign o_m0_gnt    = r_g == G_M0;
    assign o_m1_gnt    = r_g == G_M1;
    assign o_m0_rvalid = r_tag == T_M0;
    assign o_m1_rvalid = r_tag == T_M1;
    assign o_rdata     = i_ram_dout;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_write = r_ram_write;
    assign o_ram_din   = r_ram_din;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural synchronous-read RAM.
module tb_mem_arbiter;
    logic        clk, rst;
    logic [1:0]  m0_cmd, m1_cmd;
    logic [8:0]  m0_addr, m1_addr;
    logic [15:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [15:0] rdata, ram_din, ram_dout;
    logic [8:0]  ram_addr;
    logic        ram_write;
    logic        pre_we;
    logic [8:0]  pre_addr;
    logic [15:0] pre_data;
    logic [15:0] mem [0:511];

    typedef struct packed {logic m; logic [8:0] addr; logic w; logic [15:0] din;} gexp_t;
    typedef struct packed {logic m; logic [15:0] data;} rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];
    int checks = 0, failures = 0;

    mem_arbiter dut (
        .i_clk(clk), .i_reset(rst),
        .i_m0_cmd(m0_cmd), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid),
        .i_m1_cmd(m1_cmd), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid),
        .o_rdata(rdata), .o_ram_addr(ram_addr), .o_ram_write(ram_write),
        .o_ram_din(ram_din), .i_ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_write) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        if (m) begin m1_cmd = c; m1_addr = a; m1_wdata = d; end
        else begin m0_cmd = c; m0_addr = a; m0_wdata = d; end
    endtask

    // Hold a request until granted, then release it after the grant cycle ends.
    task automatic issue(input logic m, input logic [1:0] c, input logic [8:0] a, input logic [15:0] d, output int n);
        drive(m, c, a, d);
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (m ? m1_gnt : m0_gnt) begin n = i; break; end
        end
        tick();
        drive(m, 2'b00, a, d);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        drive(1'b0, 2'b00, '0, '0);
        drive(1'b1, 2'b00, '0, '0);
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m0_gnt"}, m0_gnt, 0);
        chk({tag, "_m1_gnt"}, m1_gnt, 0);
        chk({tag, "_m0_rvalid"}, m0_rvalid, 0);
        chk({tag, "_m1_rvalid"}, m1_rvalid, 0);
        chk({tag, "_ram_write"}, ram_write, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_din"}, ram_din, 0);
    endtask

    // Monitor: grants and read returns are matched against the queues in issue order.
    logic [1:0] exp_rv;
    logic       prev0, prev1;
    initial begin
        gexp_t ge;
        rexp_t re;
        exp_rv = 2'b00; prev0 = 1'b0; prev1 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_rv = 2'b00; prev0 = 1'b0; prev1 = 1'b0;
            end else begin
                chk("rvalid_timing", {m1_rvalid, m0_rvalid}, exp_rv);
                if (m0_rvalid || m1_rvalid) begin
                    if (rq.size() == 0) chk("rvalid_unexpected", {m1_rvalid, m0_rvalid}, 0);
                    else begin
                        re = rq.pop_front();
                        chk("rvalid_master", m1_rvalid, re.m);
                        chk("rdata", rdata, re.data);
                    end
                end
                chk("gnt_exclusive", m0_gnt & m1_gnt, 0);
                chk("m0_back_to_back", m0_gnt & prev0, 0);
                chk("m1_back_to_back", m1_gnt & prev1, 0);
                if (m0_gnt || m1_gnt) begin
                    if (gq.size() == 0) chk("gnt_unexpected", {m1_gnt, m0_gnt}, 0);
                    else begin
                        ge = gq.pop_front();
                        chk("gnt_master", m1_gnt, ge.m);
                        chk("ram_addr", ram_addr, ge.addr);
                        chk("ram_write", ram_write, ge.w);
                        chk("ram_din", ram_din, ge.din);
                    end
                end
                exp_rv = (m0_gnt && !ram_write) ? 2'b01 : (m1_gnt && !ram_write) ? 2'b10 : 2'b00;
                prev0 = m0_gnt; prev1 = m1_gnt;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        drive(1'b0, 2'b00, '0, '0);
        drive(1'b1, 2'b00, '0, '0);
        #2;
        chk_reset_outputs("reset");
        pre_we = 1'b1;
        pre_addr = 9'h005; pre_data = 16'hBEEF; tick();
        pre_addr = 9'h010; pre_data = 16'hA010; tick();
        pre_addr = 9'h020; pre_data = 16'hB020; tick();
        pre_we = 1'b0;
        rst = 1'b0;

        // Single read by master 0
        gq.push_back('{1'b0, 9'h005, 1'b0, 16'h0000});
        rq.push_back('{1'b0, 16'hBEEF});
        issue(1'b0, 2'b01, 9'h005, 16'h0000, n);
        chk("read_grant_latency", n, 1);
        repeat (2) tick();

        // Master 1 write then read back
        gq.push_back('{1'b1, 9'h1FF, 1'b1, 16'h1234});
        issue(1'b1, 2'b10, 9'h1FF, 16'h1234, n);
        chk("write_grant_latency", n, 1);
        gq.push_back('{1'b1, 9'h1FF, 1'b0, 16'h0000});
        rq.push_back('{1'b1, 16'h1234});
        issue(1'b1, 2'b01, 9'h1FF, 16'h0000, n);
        chk("readback_grant_latency", n, 1);
        repeat (3) tick();
        chk("idle_addr_hold", ram_addr, 9'h1FF);
        chk("idle_write_low", ram_write, 0);

        // Continuous contention from reset: strict alternation starting with master 0
        reset_pulse();
        for (int i = 0; i < 6; i++) begin
            gq.push_back(i % 2 ? '{1'b1, 9'h020, 1'b0, 16'h0000} : '{1'b0, 9'h010, 1'b0, 16'h0000});
            rq.push_back(i % 2 ? '{1'b1, 16'hB020} : '{1'b0, 16'hA010});
        end
        drive(1'b0, 2'b01, 9'h010, 16'h0000);
        drive(1'b1, 2'b01, 9'h020, 16'h0000);
        repeat (6) tick();
        drive(1'b0, 2'b00, 9'h010, 16'h0000);
        drive(1'b1, 2'b00, 9'h020, 16'h0000);
        repeat (3) tick();
        chk("contention_drained", gq.size(), 0);

        // Fairness pointer: a lone grant hands priority to the other master
        reset_pulse();
        gq.push_back('{1'b0, 9'h010, 1'b0, 16'h0000});
        rq.push_back('{1'b0, 16'hA010});
        issue(1'b0, 2'b01, 9'h010, 16'h0000, n);
        chk("lone_m0_latency", n, 1);
        repeat (2) tick();
        gq.push_back('{1'b1, 9'h020, 1'b0, 16'h0000});
        gq.push_back('{1'b0, 9'h010, 1'b0, 16'h0000});
        rq.push_back('{1'b1, 16'hB020});
        rq.push_back('{1'b0, 16'hA010});
        drive(1'b0, 2'b01, 9'h010, 16'h0000);
        drive(1'b1, 2'b01, 9'h020, 16'h0000);
        repeat (2) tick();
        drive(1'b0, 2'b00, 9'h010, 16'h0000);
        drive(1'b1, 2'b00, 9'h020, 16'h0000);
        repeat (2) tick();
        gq.push_back('{1'b1, 9'h020, 1'b0, 16'h0000});
        rq.push_back('{1'b1, 16'hB020});
        issue(1'b1, 2'b01, 9'h020, 16'h0000, n);
        chk("lone_m1_latency", n, 1);
        repeat (2) tick();
        gq.push_back('{1'b0, 9'h010, 1'b0, 16'h0000});
        gq.push_back('{1'b1, 9'h020, 1'b0, 16'h0000});
        rq.push_back('{1'b0, 16'hA010});
        rq.push_back('{1'b1, 16'hB020});
        drive(1'b0, 2'b01, 9'h010, 16'h0000);
        drive(1'b1, 2'b01, 9'h020, 16'h0000);
        repeat (2) tick();
        drive(1'b0, 2'b00, 9'h010, 16'h0000);
        drive(1'b1, 2'b00, 9'h020, 16'h0000);
        repeat (3) tick();

        // Held request: grants on cycles 1 and 3 only
        gq.push_back('{1'b0, 9'h005, 1'b0, 16'h0000});
        gq.push_back('{1'b0, 9'h005, 1'b0, 16'h0000});
        rq.push_back('{1'b0, 16'hBEEF});
        rq.push_back('{1'b0, 16'hBEEF});
        drive(1'b0, 2'b01, 9'h005, 16'h0000);
        tick(); chk("held_c1_gnt", m0_gnt, 1);
        tick(); chk("held_c2_gnt", m0_gnt, 0);
        tick(); chk("held_c3_gnt", m0_gnt, 1);
        tick(); chk("held_c4_gnt", m0_gnt, 0);
        drive(1'b0, 2'b00, 9'h005, 16'h0000);
        repeat (3) tick();

        // Asynchronous reset while a read is in flight
        drive(1'b0, 2'b01, 9'h005, 16'h5A5A);
        tick();
        chk("midread_gnt", m0_gnt, 1);
        chk("midread_din", ram_din, 16'h5A5A);
        #1;
        rst = 1'b1;
        drive(1'b0, 2'b00, 9'h005, 16'h5A5A);
        #1;
        chk_reset_outputs("async_reset");
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midread_no_rvalid", m0_rvalid, 0);
        end

        // Reserved command encoding is ignored on both masters
        drive(1'b0, 2'b11, 9'h033, 16'h1111);
        drive(1'b1, 2'b11, 9'h044, 16'h2222);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("illegal_m0_gnt", m0_gnt, 0);
            chk("illegal_m1_gnt", m1_gnt, 0);
            chk("illegal_ram_write", ram_write, 0);
        end
        drive(1'b0, 2'b00, '0, '0);
        drive(1'b1, 2'b00, '0, '0);
        repeat (3) tick();

        chk("gnt_queue_empty", gq.size(), 0);
        chk("rvalid_queue_empty", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
